serial_adder: RTL

Bit-serial adder that sums two WIDTH-bit operands plus carry-in over WIDTH clock cycles, LSB first. It uses one full-adder cell (sum = a^b^c, carry = majority) and a registered carry, with operand and result shift registers around it. It sits directly downstream of operand capture and replaces a WIDTH-wide ripple of full-adder cells wherever area matters more than latency. A start/busy/done handshake hands results to the consumer.

---
 rtl/serial_adder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: computes (a + b + cin) over WIDTH clock cycles, LSB
//   first, using one full-adder cell and a registered carry. Operands are
//   captured into shift registers on the accepting edge, so later changes on
//   a/b/cin do not disturb the running addition. The result is built in a
//   working shift register and copied to the sum/cout output registers on the
//   final RUN cycle, so sum/cout hold the previous result until the next done.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request an addition; accepted in IDLE or in the DONE cycle
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   busy   out  high while the addition runs (registered)
//   done   out  one-cycle pulse when sum/cout are valid (registered)
//   sum    out  (a + b + cin) mod 2^WIDTH (registered)
//   cout   out  carry out of bit WIDTH-1 (registered)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             busy_next;
  logic             done_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic             bit_sum;
  logic             carry_next;

  // A start is only honoured when no addition is in flight.
  assign accept     = start && ((state == S_IDLE) || (state == S_DONE));
  assign last       = (cnt == CW'(1));

  // Single full-adder cell.
  assign bit_sum    = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_next = (a_sh[0] & b_sh[0]) | (b_sh[0] & carry) | (a_sh[0] & carry);

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  if (WIDTH == 1) begin : g_acc_one
    assign acc_next = bit_sum;
  end else begin : g_acc_multi
    assign acc_next = {bit_sum, acc[WIDTH-1:1]};
  end

  // State register; busy/done are registered alongside it from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE: begin
        if (accept) next_state = S_RUN;
        else        next_state = S_IDLE;
      end
      S_RUN: begin
        if (last) next_state = S_DONE;
        else      next_state = S_RUN;
      end
      S_DONE: begin
        if (accept) next_state = S_RUN;
        else        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the flops show the state being entered.
  always_comb begin
    busy_next = 1'b0;
    done_next = 1'b0;
    case (next_state)
      S_RUN:   busy_next = 1'b1;
      S_DONE:  done_next = 1'b1;
      default: begin
        busy_next = 1'b0;
        done_next = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, serial shifting, and result hand-off on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      acc   <= '0;
      cnt   <= CW'(WIDTH);
    end else if (state == S_RUN) begin
      a_sh  <= a_sh >> 1'b1;
      b_sh  <= b_sh >> 1'b1;
      carry <= carry_next;
      acc   <= acc_next;
      cnt   <= cnt - CW'(1);
      if (last) begin
        sum  <= acc_next;
        cout <= carry_next;
      end else begin
        sum  <= sum;
        cout <= cout;
      end
    end else begin
      a_sh  <= a_sh;
      b_sh  <= b_sh;
      carry <= carry;
      acc   <= acc;
      cnt   <= cnt;
    end
  end

endmodule
